// File: rtl/boot_sequencer_pkg.sv
// Shared boot-sequencer definitions: state encoding, clock-derived timing defaults, helpers.
package boot_sequencer_pkg;

  localparam int CLOCK_HZ                = 48_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLOCK_HZ / 100;  // 10 ms
  localparam int DEFAULT_WARMUP_CYCLES   = CLOCK_HZ / 10;   // 100 ms
  localparam int DEFAULT_LOAD_TIMEOUT    = CLOCK_HZ;        // 1 s

  typedef enum logic [2:0] {
    BOOT_IDLE     = 3'd0,
    BOOT_DEBOUNCE = 3'd1,
    BOOT_LATCH    = 3'd2,
    BOOT_LOAD     = 3'd3,
    BOOT_WARMUP   = 3'd4,
    BOOT_READY    = 3'd5,
    BOOT_ERROR    = 3'd6
  } boot_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/boot_sequencer_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs; flops clear on reset.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Power-up controller: debounces power_good, latches the image select, drives the SPI loader,
// waits out the bubble warm-up and then enables the bubble interface.
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int WARMUP_CYCLES   = DEFAULT_WARMUP_CYCLES,
  parameter int LOAD_TIMEOUT    = DEFAULT_LOAD_TIMEOUT
) (
  input  logic        master_clock,
  input  logic        reset_n,
  input  logic        power_good,
  input  logic [2:0]  image_dip_switch,
  input  logic        flash_error,
  input  logic        loader_done,
  output logic        loader_start,
  output logic [2:0]  image_number,
  output logic        bubble_interface_enable,
  output logic        temperature_low,
  output logic        boot_error,
  output boot_state_t state
);

  if (DEBOUNCE_CYCLES < 2 || WARMUP_CYCLES < 2 || LOAD_TIMEOUT < 2) begin : g_param_check
    $error("boot_sequencer: all cycle parameters must be >= 2");
  end

  localparam int MAX_CYCLES = max3(DEBOUNCE_CYCLES, WARMUP_CYCLES, LOAD_TIMEOUT);
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARMUP_LAST   = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST     = CNT_W'(LOAD_TIMEOUT - 1);

  logic             pg_s;
  logic [CNT_W-1:0] count;

  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_pg_sync (
    .clk     (master_clock),
    .reset_n (reset_n),
    .d       (power_good),
    .q       (pg_s)
  );

  // Loader handshake: loader_start is a one-cycle request issued once per boot (the cycle after
  // LATCH); the loader answers with either a one-cycle loader_done pulse or a flash_error level.
  // Both answers are sampled only in LOAD; flash_error wins a same-cycle tie.
  always_ff @(posedge master_clock) begin
    if (!reset_n) begin
      state                   <= BOOT_IDLE;
      count                   <= '0;
      loader_start            <= 1'b0;
      image_number            <= 3'b000;
      bubble_interface_enable <= 1'b1;
      temperature_low         <= 1'b1;
      boot_error              <= 1'b0;
    end else begin
      loader_start <= 1'b0;
      if (!pg_s) begin
        // Power loss beats every other transition; image_number is kept for inspection.
        state                   <= BOOT_IDLE;
        count                   <= '0;
        bubble_interface_enable <= 1'b1;
        temperature_low         <= 1'b1;
        boot_error              <= 1'b0;
      end else begin
        unique case (state)
          BOOT_IDLE: begin
            count <= '0;
            state <= BOOT_DEBOUNCE;
          end
          BOOT_DEBOUNCE: begin
            if (count == DEBOUNCE_LAST) begin
              count <= '0;
              state <= BOOT_LATCH;
            end else begin
              count <= count + 1'b1;
            end
          end
          BOOT_LATCH: begin
            image_number <= ~image_dip_switch;
            loader_start <= 1'b1;
            count        <= '0;
            state        <= BOOT_LOAD;
          end
          BOOT_LOAD: begin
            if (flash_error) begin
              boot_error <= 1'b1;
              state      <= BOOT_ERROR;
            end else if (loader_done) begin
              count <= '0;
              state <= BOOT_WARMUP;
            end else if (count == LOAD_LAST) begin
              boot_error <= 1'b1;
              state      <= BOOT_ERROR;
            end else begin
              count <= count + 1'b1;
            end
          end
          BOOT_WARMUP: begin
            if (count == WARMUP_LAST) begin
              bubble_interface_enable <= 1'b0;
              temperature_low         <= 1'b0;
              state                   <= BOOT_READY;
            end else begin
              count <= count + 1'b1;
            end
          end
          BOOT_READY: begin
            state <= BOOT_READY;
          end
          BOOT_ERROR: begin
            state <= BOOT_ERROR;
          end
          default: begin
            count <= '0;
            state <= BOOT_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer with a run-length based reference model checked every cycle.
module tb_boot_sequencer;
  import boot_sequencer_pkg::*;

  localparam int D = 4;
  localparam int W = 16;
  localparam int T = 64;

  logic        master_clock = 1'b0;
  logic        reset_n;
  logic        power_good;
  logic [2:0]  image_dip_switch;
  logic        flash_error;
  logic        loader_done;
  logic        loader_start;
  logic [2:0]  image_number;
  logic        bubble_interface_enable;
  logic        temperature_low;
  logic        boot_error;
  boot_state_t state;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int start_count = 0;
  bit armed = 1'b0;
  bit beyond_debounce = 1'b0;
  logic [2:0] exp_q[$];

  // Model: length of the current unbroken run of synchronised power_good highs, plus the run
  // index at which the load completed and whether the boot failed.
  int         m_run = 0;
  int         m_done_at = 0;
  bit         m_err = 1'b0;
  bit         m_s1 = 1'b0;
  bit         m_s2 = 1'b0;
  logic [2:0] m_img = 3'b000;

  boot_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .WARMUP_CYCLES   (W),
    .LOAD_TIMEOUT    (T)
  ) dut (
    .master_clock            (master_clock),
    .reset_n                 (reset_n),
    .power_good              (power_good),
    .image_dip_switch        (image_dip_switch),
    .flash_error             (flash_error),
    .loader_done             (loader_done),
    .loader_start            (loader_start),
    .image_number            (image_number),
    .bubble_interface_enable (bubble_interface_enable),
    .temperature_low         (temperature_low),
    .boot_error              (boot_error),
    .state                   (state)
  );

  // Clock / watchdog
  always #5 master_clock = ~master_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic compare_outputs();
    bit          ready;
    boot_state_t es;
    logic [2:0]  qimg;
    ready = (m_done_at != 0) && (m_run >= m_done_at + W);
    if (m_err)                es = BOOT_ERROR;
    else if (ready)           es = BOOT_READY;
    else if (m_done_at != 0)  es = BOOT_WARMUP;
    else if (m_run >= D + 2)  es = BOOT_LOAD;
    else if (m_run == D + 1)  es = BOOT_LATCH;
    else if (m_run >= 1)      es = BOOT_DEBOUNCE;
    else                      es = BOOT_IDLE;
    check("start",      32'(loader_start),            32'(m_run == D + 2));
    check("image",      32'(image_number),            32'(m_img));
    check("enable",     32'(bubble_interface_enable), 32'(!ready));
    check("temp_low",   32'(temperature_low),         32'(!ready));
    check("boot_error", 32'(boot_error),              32'(m_err));
    check("state",      32'(state),                   32'(es));
    if (loader_start === 1'b1) begin
      check("start_queued", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        qimg = exp_q.pop_front();
        check("start_image", 32'(image_number), 32'(qimg));
      end
    end
  endtask

  // Model update and per-cycle compare
  always @(posedge master_clock) begin
    logic       rst_c, pg_c, fe_c, ld_c, pg_seen;
    logic [2:0] dip_c;
    rst_c = reset_n;
    pg_c  = power_good;
    fe_c  = flash_error;
    ld_c  = loader_done;
    dip_c = image_dip_switch;
    cycle++;
    #1;
    if (!rst_c) begin
      m_run = 0; m_done_at = 0; m_err = 1'b0; m_img = 3'b000; m_s1 = 1'b0; m_s2 = 1'b0;
      armed = 1'b1;
    end else begin
      pg_seen = m_s2;
      m_s2 = m_s1;
      m_s1 = pg_c;
      if (!pg_seen) begin
        m_run = 0; m_done_at = 0; m_err = 1'b0;
      end else begin
        m_run++;
        if (m_run == D + 2) begin
          m_img = ~dip_c;
          exp_q.push_back(m_img);
        end
        if (m_run >= D + 3 && m_done_at == 0 && !m_err) begin
          if (fe_c)                 m_err = 1'b1;
          else if (ld_c)            m_done_at = m_run;
          else if (m_run == D + 2 + T) m_err = 1'b1;
        end
      end
    end
    if (armed) compare_outputs();
    if (loader_start === 1'b1) start_count++;
    if (state != BOOT_IDLE && state != BOOT_DEBOUNCE) beyond_debounce = 1'b1;
  end

  // Driver tasks
  task automatic do_reset();
    reset_n = 1'b0; power_good = 1'b0; flash_error = 1'b0; loader_done = 1'b0;
    repeat (2) @(negedge master_clock);
    reset_n = 1'b1;
  endtask

  task automatic pulse_done();
    loader_done = 1'b1;
    @(negedge master_clock);
    loader_done = 1'b0;
  endtask

  // sel: 0 start high, 1 enable low, 2 boot_error high, 3 state LATCH, 4 boot_error low
  task automatic wait_sig(input int sel, input int limit, output int edge_no, output bit seen);
    seen = 1'b0;
    edge_no = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge master_clock);
      case (sel)
        0:       seen = (loader_start === 1'b1);
        1:       seen = (bubble_interface_enable === 1'b0);
        2:       seen = (boot_error === 1'b1);
        3:       seen = (state === BOOT_LATCH);
        default: seen = (boot_error === 1'b0);
      endcase
      if (seen) edge_no = cycle;
    end
  endtask

  initial begin
    int e_start, e_done, e_ready, e_err, e_tmp;
    bit seen;
    reset_n = 1'b0; power_good = 1'b0; image_dip_switch = 3'b111;
    flash_error = 1'b0; loader_done = 1'b0;
    repeat (3) @(negedge master_clock);
    check("rst_start",  32'(loader_start), 32'd0);
    check("rst_image",  32'(image_number), 32'd0);
    check("rst_enable", 32'(bubble_interface_enable), 32'd1);
    check("rst_temp",   32'(temperature_low), 32'd1);
    check("rst_error",  32'(boot_error), 32'd0);
    check("rst_state",  32'(state), 32'(BOOT_IDLE));
    reset_n = 1'b1;
    @(negedge master_clock);

    // Nominal boot
    start_count = 0;
    image_dip_switch = 3'b101;
    power_good = 1'b1;
    wait_sig(0, 100, e_start, seen);
    check("t1_start_seen", 32'(seen), 32'd1);
    check("t1_image", 32'(image_number), 32'(3'b010));
    repeat (9) @(negedge master_clock);
    e_done = cycle + 1;
    pulse_done();
    wait_sig(1, 100, e_ready, seen);
    check("t1_ready_seen", 32'(seen), 32'd1);
    check("t1_ready_latency", 32'(e_ready - e_done), 32'd16);
    check("t1_temp_low", 32'(temperature_low), 32'd0);
    repeat (20) @(negedge master_clock);
    check("t1_one_start", 32'(start_count), 32'd1);
    check("t1_still_ready", 32'(bubble_interface_enable), 32'd0);

    // Power loss in READY, then re-power with a new image
    power_good = 1'b0;
    repeat (2) @(negedge master_clock);
    check("t5_enable_edge2", 32'(bubble_interface_enable), 32'd0);
    @(negedge master_clock);
    check("t5_enable_edge3", 32'(bubble_interface_enable), 32'd1);
    check("t5_temp_edge3", 32'(temperature_low), 32'd1);
    check("t5_image_held", 32'(image_number), 32'(3'b010));
    image_dip_switch = 3'b000;
    power_good = 1'b1;
    wait_sig(0, 100, e_tmp, seen);
    check("t5_start_seen", 32'(seen), 32'd1);
    check("t5_image", 32'(image_number), 32'(3'b111));
    repeat (3) @(negedge master_clock);
    pulse_done();
    repeat (25) @(negedge master_clock);
    check("t5_ready_again", 32'(bubble_interface_enable), 32'd0);

    // Glitchy power_good never gets past debounce
    do_reset();
    start_count = 0;
    beyond_debounce = 1'b0;
    repeat (4) begin
      power_good = 1'b1;
      repeat (3) @(negedge master_clock);
      power_good = 1'b0;
      repeat (4) @(negedge master_clock);
    end
    check("t2_no_start", 32'(start_count), 32'd0);
    check("t2_stayed_debounce", 32'(beyond_debounce), 32'd0);

    // Flash error at LOAD cycle 5; later loader_done ignored
    do_reset();
    image_dip_switch = 3'b011;
    power_good = 1'b1;
    wait_sig(0, 100, e_tmp, seen);
    check("t3_start_seen", 32'(seen), 32'd1);
    repeat (5) @(negedge master_clock);
    flash_error = 1'b1;
    @(negedge master_clock);
    flash_error = 1'b0;
    repeat (3) @(negedge master_clock);
    pulse_done();
    repeat (5) @(negedge master_clock);
    check("t3_error", 32'(boot_error), 32'd1);
    check("t3_enable", 32'(bubble_interface_enable), 32'd1);
    check("t3_temp", 32'(temperature_low), 32'd1);
    check("t3_state", 32'(state), 32'(BOOT_ERROR));

    // Load timeout
    do_reset();
    power_good = 1'b1;
    wait_sig(0, 100, e_start, seen);
    check("t4_start_seen", 32'(seen), 32'd1);
    wait_sig(2, 150, e_err, seen);
    check("t4_error_seen", 32'(seen), 32'd1);
    check("t4_timeout_cycles", 32'(e_err - e_start), 32'd64);
    power_good = 1'b0;
    wait_sig(4, 3, e_tmp, seen);
    check("t4_error_cleared", 32'(seen), 32'd1);
    check("t4_idle", 32'(state), 32'(BOOT_IDLE));

    // Reset during WARMUP
    do_reset();
    image_dip_switch = 3'b110;
    power_good = 1'b1;
    wait_sig(0, 100, e_tmp, seen);
    check("t6_start_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge master_clock);
    pulse_done();
    repeat (5) @(negedge master_clock);
    check("t6_in_warmup", 32'(state), 32'(BOOT_WARMUP));
    reset_n = 1'b0;
    @(negedge master_clock);
    check("t6w_state", 32'(state), 32'(BOOT_IDLE));
    check("t6w_image", 32'(image_number), 32'd0);
    check("t6w_enable", 32'(bubble_interface_enable), 32'd1);
    check("t6w_temp", 32'(temperature_low), 32'd1);

    // Reset during the LATCH cycle
    do_reset();
    start_count = 0;
    power_good = 1'b1;
    wait_sig(3, 50, e_tmp, seen);
    check("t6_latch_seen", 32'(seen), 32'd1);
    reset_n = 1'b0;
    @(negedge master_clock);
    check("t6l_start", 32'(loader_start), 32'd0);
    check("t6l_image", 32'(image_number), 32'd0);
    check("t6l_state", 32'(state), 32'(BOOT_IDLE));
    reset_n = 1'b1;
    power_good = 1'b0;
    repeat (3) @(negedge master_clock);
    check("t6l_no_start", 32'(start_count), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
